// File: rtl/load_data_unit.sv
// load_data_unit: MEM-stage load engine.
// Issues word-aligned reads on an sram-like data bus, extracts and extends the
// requested byte/halfword/word, raises the pipeline stall while a load is in
// flight and flags misaligned loads (AdEL).
//
// Handshake: a read address is transferred in the cycle where
// data_req & data_addr_ok are both 1; data_req and data_addr stay stable until
// then. A read word is transferred in any cycle where data_data_ok is 1 while a
// read is outstanding. Only one read is ever outstanding.
module load_data_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [2:0]        ld_con,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              flush,
  output logic              data_req,
  output logic [ADDR_W-1:0] data_addr,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       ld_result,
  output logic              ld_done,
  output logic              ld_stall,
  output logic              adel,
  output logic [ADDR_W-1:0] badvaddr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_con;
  logic [31:0]       r_result;
  logic              r_done;
  logic              r_adel;
  logic [ADDR_W-1:0] r_badvaddr;

  logic              w_legal;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_capture;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  // Decode the incoming load: legality, alignment and the accept condition.
  // The load that just completed is still sitting in MEM during the ld_done
  // cycle, so accepting is blocked then to avoid issuing it a second time.
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    case (ld_con)
      LD_LW: begin
        w_legal      = 1'b1;
        w_misaligned = (ld_addr[1:0] != 2'b00);
      end
      LD_LH, LD_LHU: begin
        w_legal      = 1'b1;
        w_misaligned = ld_addr[0];
      end
      LD_LB, LD_LBU: begin
        w_legal      = 1'b1;
        w_misaligned = 1'b0;
      end
      default: begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
      end
    endcase
    w_accept = (r_state == S_IDLE) & ld_valid & w_legal & ~flush & ~r_done;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; w_capture marks a returned word that belongs to a live load.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_misaligned) w_next = S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            w_next    = S_IDLE;
            w_capture = ~flush;
          end else begin
            w_next = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_next    = S_IDLE;
          w_capture = ~flush;
        end else if (flush) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (data_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pick the addressed byte/halfword and extend it according to the latched load type.
  always_comb begin
    w_off = r_addr[1:0];
    case (w_off)
      2'd0:    w_byte = data_rdata[7:0];
      2'd1:    w_byte = data_rdata[15:8];
      2'd2:    w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = w_off[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_con)
      LD_LH:   w_ext = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_ext = {16'h0000, w_half};
      LD_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_ext = {24'h000000, w_byte};
      default: w_ext = data_rdata;
    endcase
  end

  // Load context, result, completion pulse and AdEL reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_con      <= 3'b000;
      r_result   <= 32'h0;
      r_done     <= 1'b0;
      r_adel     <= 1'b0;
      r_badvaddr <= '0;
    end else begin
      r_done <= w_capture;
      r_adel <= w_accept & w_misaligned;
      if (w_accept && w_misaligned) r_badvaddr <= ld_addr;
      if (w_accept && !w_misaligned) begin
        r_addr <= ld_addr;
        r_con  <= ld_con;
      end
      if (w_capture) r_result <= w_ext;
    end
  end

  // Bus and pipeline-facing outputs.
  always_comb begin
    data_req  = (r_state == S_REQ);
    data_addr = {r_addr[ADDR_W-1:2], 2'b00};
    ld_stall  = (r_state != S_IDLE) | (w_accept & ~w_misaligned);
    ld_result = r_result;
    ld_done   = r_done;
    adel      = r_adel;
    badvaddr  = r_badvaddr;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_load_data_unit.sv
// tb_load_data_unit: directed load sequences against a scoreboard.
// Stimulus pushes the expected ld_result / badvaddr into queues; a monitor on
// the falling edge pops and compares whenever ld_done or adel is presented.
`timescale 1ns/1ps
module tb_load_data_unit;

  localparam logic [2:0] LW  = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LB  = 3'b100;
  localparam logic [2:0] LBU = 3'b101;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [2:0]  ld_con;
  logic [31:0] ld_addr;
  logic        flush;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] ld_result;
  logic        ld_done;
  logic        ld_stall;
  logic        adel;
  logic [31:0] badvaddr;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] adel_q[$];
  logic [31:0] mon_e;
  int          n_tests;
  int          n_fail;

  load_data_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_con(ld_con), .ld_addr(ld_addr),
    .flush(flush), .data_req(data_req), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ld_result(ld_result), .ld_done(ld_done), .ld_stall(ld_stall), .adel(adel),
    .badvaddr(badvaddr), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ld_done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ld_done: ld_result 0x%08h with nothing expected", ld_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_ld_result", ld_result, mon_e);
        end
      end
      if (adel) begin
        if (adel_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_adel: badvaddr 0x%08h with nothing expected", badvaddr);
        end else begin
          mon_e = adel_q.pop_front();
          check("sb_badvaddr", badvaddr, mon_e);
        end
      end
    end
  end

  // driver: one aligned load; entered just after a rising edge
  task automatic run_load(input logic [2:0] con, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp,
                          input int addr_wait, input bit same_cycle);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    ld_valid = 1'b1;
    ld_con   = con;
    ld_addr  = addr;
    exp_q.push_back(exp);
    #1;
    check("stall_accept", {31'd0, ld_stall}, 32'd1);
    check("req_in_accept", {31'd0, data_req}, 32'd0);
    tick();
    for (int i = 0; i < addr_wait; i++) begin
      check("req_hold", {31'd0, data_req}, 32'd1);
      check("addr_hold", data_addr, waddr);
      check("stall_hold", {31'd0, ld_stall}, 32'd1);
      tick();
    end
    check("data_req", {31'd0, data_req}, 32'd1);
    check("data_addr", data_addr, waddr);
    data_addr_ok = 1'b1;
    if (same_cycle) begin
      data_data_ok = 1'b1;
      data_rdata   = rdata;
    end
    tick();
    data_addr_ok = 1'b0;
    if (!same_cycle) begin
      check("stall_wait", {31'd0, ld_stall}, 32'd1);
      check("done_early", {31'd0, ld_done}, 32'd0);
      data_data_ok = 1'b1;
      data_rdata   = rdata;
      tick();
    end
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    check("done_latency", {31'd0, ld_done}, 32'd1);
    check("stall_in_done", {31'd0, ld_stall}, 32'd0);
    tick();
    ld_valid = 1'b0;
    check("done_pulse_end", {31'd0, ld_done}, 32'd0);
  endtask

  // driver: one misaligned load
  task automatic run_misaligned(input logic [2:0] con, input logic [31:0] addr);
    ld_valid = 1'b1;
    ld_con   = con;
    ld_addr  = addr;
    adel_q.push_back(addr);
    #1;
    check("stall_misaligned", {31'd0, ld_stall}, 32'd0);
    tick();
    ld_valid = 1'b0;
    check("adel_pulse", {31'd0, adel}, 32'd1);
    check("badvaddr", badvaddr, addr);
    check("req_misaligned", {31'd0, data_req}, 32'd0);
    tick();
    check("adel_clear", {31'd0, adel}, 32'd0);
    check("req_misaligned2", {31'd0, data_req}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_con = 3'b000;
    ld_addr = 32'h0;
    flush = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    repeat (3) tick();

    // reset state
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_ld_done", {31'd0, ld_done}, 32'd0);
    check("rst_adel", {31'd0, adel}, 32'd0);
    check("rst_stall", {31'd0, ld_stall}, 32'd0);
    check("rst_ld_result", ld_result, 32'h0);
    check("rst_badvaddr", badvaddr, 32'h0);
    check("rst_data_addr", data_addr, 32'h0);
    rst = 1'b0;
    tick();

    // LW with addr_ok in first REQ cycle, data next cycle
    run_load(LW, 32'h1000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
    check("result_hold", ld_result, 32'hDEAD_BEEF);

    // byte extraction, rdata 0x8012_3456
    run_load(LB,  32'h2000_0003, 32'h8012_3456, 32'hFFFF_FF80, 0, 1'b0);
    run_load(LBU, 32'h2000_0003, 32'h8012_3456, 32'h0000_0080, 0, 1'b0);
    run_load(LB,  32'h2000_0000, 32'h8012_3456, 32'h0000_0056, 0, 1'b1);
    run_load(LBU, 32'h2000_0001, 32'h8012_3456, 32'h0000_0034, 0, 1'b1);
    run_load(LB,  32'h2000_0002, 32'h8012_3456, 32'h0000_0012, 0, 1'b0);

    // halfword extraction, rdata 0x8001_7FFF
    run_load(LH,  32'h3000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 0, 1'b0);
    run_load(LHU, 32'h3000_0002, 32'h8001_7FFF, 32'h0000_8001, 0, 1'b1);
    run_load(LH,  32'h3000_0000, 32'h8001_7FFF, 32'h0000_7FFF, 0, 1'b0);

    // misaligned loads
    run_misaligned(LW, 32'h1000_0002);
    run_misaligned(LH, 32'h1000_0101);

    // addr_ok held off for 5 cycles
    run_load(LW, 32'h4000_0010, 32'h1234_5678, 32'h1234_5678, 5, 1'b0);

    // flush in WAIT, drain, then back-to-back load issues after drain
    ld_valid = 1'b1;
    ld_con   = LW;
    ld_addr  = 32'h1000_0100;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ld_addr = 32'h1000_0200;
    check("drain_state", {30'd0, dbg_state}, 32'd3);
    check("drain_req1", {31'd0, data_req}, 32'd0);
    check("drain_stall1", {31'd0, ld_stall}, 32'd1);
    tick();
    check("drain_req2", {31'd0, data_req}, 32'd0);
    check("drain_stall2", {31'd0, ld_stall}, 32'd1);
    data_data_ok = 1'b1;
    data_rdata   = 32'hBAD0_BAD0;
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    check("flushed_no_done", {31'd0, ld_done}, 32'd0);
    check("post_drain_req", {31'd0, data_req}, 32'd0);
    check("post_drain_stall", {31'd0, ld_stall}, 32'd1);
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    check("b2b_req", {31'd0, data_req}, 32'd1);
    check("b2b_addr", data_addr, 32'h1000_0200);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    check("b2b_done", {31'd0, ld_done}, 32'd1);
    tick();
    ld_valid = 1'b0;

    // flush in REQ before addr_ok drops the request
    ld_valid = 1'b1;
    ld_con   = LBU;
    ld_addr  = 32'h5000_0001;
    tick();
    flush = 1'b1;
    check("flush_req_before", {31'd0, data_req}, 32'd1);
    tick();
    flush = 1'b0;
    ld_valid = 1'b0;
    check("flush_req_dropped", {31'd0, data_req}, 32'd0);
    tick();
    check("flush_req_no_done", {31'd0, ld_done}, 32'd0);

    // reset mid-load; late data_ok ignored
    ld_valid = 1'b1;
    ld_con   = LW;
    ld_addr  = 32'h6000_0000;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    rst = 1'b1;
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_AAAA;
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mid_stall", {31'd0, ld_stall}, 32'd0);
    tick();
    data_data_ok = 1'b0;
    check("rst_mid_no_done", {31'd0, ld_done}, 32'd0);
    check("rst_mid_result", ld_result, 32'h0);
    repeat (2) tick();

    // every expected response consumed
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("adel_q_empty", adel_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
